// File: rtl/pc_unit.sv
// Program counter with conditional/unconditional load, alignment check,
// exception redirect with EPC capture, and a circular return-address stack.
module pc_unit #(
    parameter int unsigned            WIDTH        = 32,
    parameter logic [WIDTH-1:0]       RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0]       EXC_VECTOR   = WIDTH'(32'h0000_00FC),
    parameter int unsigned            RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pc_write,
    input  logic             pc_write_cond,
    input  logic             zero,
    input  logic [1:0]       pc_src,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] jump_target,
    input  logic [WIDTH-1:0] reg_target,
    input  logic             exc_req,
    input  logic             ras_push,
    input  logic             ras_pop,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_unf,
    output logic             misalign
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] sel_pc;
    logic             load;
    logic             bad_align;

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    top_ptr, top_nxt, wr_idx;
    logic [PW:0]      cnt, cnt_nxt;
    logic             wr_en, set_ovf, set_unf;
    logic             do_push, do_pop;

    // Next-PC candidate selection and load qualification
    always_comb begin
        seq_pc = pc + WIDTH'(4);
        sel_pc = seq_pc;
        case (pc_src)
            2'b00: sel_pc = seq_pc;
            2'b01: sel_pc = branch_target;
            2'b10: sel_pc = jump_target;
            2'b11: sel_pc = reg_target;
            default: sel_pc = seq_pc;
        endcase
        load      = pc_write | (pc_write_cond & zero);
        bad_align = sel_pc[1:0] != 2'b00;
    end

    // PC, EPC and misalign pulse; exception overrides any load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= RESET_VECTOR;
            epc      <= '0;
            misalign <= 1'b0;
        end else if (exc_req) begin
            pc       <= EXC_VECTOR;
            epc      <= pc;
            misalign <= 1'b0;
        end else begin
            misalign <= load & bad_align;
            if (load && !bad_align)
                pc <= sel_pc;
        end
    end

    assign ras_empty = (cnt == '0);
    assign ras_full  = (cnt == (PW+1)'(RAS_DEPTH));
    assign do_push   = ras_push & ~exc_req;
    assign do_pop    = ras_pop  & ~exc_req;

    // RAS next state; a push always lands at top+1, which on a full stack
    // is exactly the oldest slot, so overflow needs no special addressing
    always_comb begin
        top_nxt = top_ptr;
        cnt_nxt = cnt;
        wr_en   = 1'b0;
        wr_idx  = top_ptr + PW'(1);
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (do_push && do_pop && !ras_empty) begin
            wr_en  = 1'b1;
            wr_idx = top_ptr;
        end else if (do_push) begin
            wr_en   = 1'b1;
            top_nxt = top_ptr + PW'(1);
            if (ras_full) set_ovf = 1'b1;
            else          cnt_nxt = cnt + 1'b1;
        end else if (do_pop) begin
            if (ras_empty) begin
                set_unf = 1'b1;
            end else begin
                top_nxt = top_ptr - PW'(1);
                cnt_nxt = cnt - 1'b1;
            end
        end
    end

    // RAS pointer, occupancy and sticky error flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            top_ptr <= '0;
            cnt     <= '0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            top_ptr <= top_nxt;
            cnt     <= cnt_nxt;
            if (set_ovf) ras_ovf <= 1'b1;
            if (set_unf) ras_unf <= 1'b1;
        end
    end

    // RAS entry storage; contents are hidden while the stack is empty
    always_ff @(posedge clk) begin
        if (wr_en && reset_n)
            ras_mem[wr_idx] <= seq_pc;
    end

    assign ras_top = ras_empty ? '0 : ras_mem[top_ptr];

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: load paths, alignment, exception, RAS, reset.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pc_write, pc_write_cond, zero;
    logic [1:0]  pc_src;
    logic [31:0] branch_target, jump_target, reg_target;
    logic        exc_req, ras_push, ras_pop;
    logic [31:0] pc, epc, ras_top;
    logic        ras_empty, ras_full, ras_ovf, ras_unf, misalign;

    int tests = 0;
    int fails = 0;

    pc_unit dut (
        .clk(clk), .reset_n(reset_n),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .zero(zero),
        .pc_src(pc_src), .branch_target(branch_target),
        .jump_target(jump_target), .reg_target(reg_target),
        .exc_req(exc_req), .ras_push(ras_push), .ras_pop(ras_pop),
        .pc(pc), .epc(epc), .ras_top(ras_top),
        .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one clock edge, then settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc_write = 0; pc_write_cond = 0; zero = 0; pc_src = 2'b00;
        exc_req = 0; ras_push = 0; ras_pop = 0;
    endtask

    task automatic jump(input logic [31:0] a);
        idle();
        pc_write = 1; pc_src = 2'b10; jump_target = a;
        step();
        idle();
    endtask

    logic [31:0] exp_top [4];

    initial begin
        reset_n = 0;
        idle();
        branch_target = 0; jump_target = 0; reg_target = 0;
        #3;
        chk("rst_pc", pc, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_top", ras_top, 32'h0);
        chk("rst_flags", {ras_empty, ras_full, ras_ovf, ras_unf, misalign}, 5'b10000);
        @(negedge clk);
        reset_n = 1;

        // sequential increments
        pc_write = 1; pc_src = 2'b00;
        step(); chk("seq1", pc, 32'h4);
        step(); chk("seq2", pc, 32'h8);
        step(); chk("seq3", pc, 32'hC);

        // conditional branch
        jump(32'h40); chk("jump40", pc, 32'h40);
        pc_write_cond = 1; zero = 0; pc_src = 2'b01; branch_target = 32'h80;
        step(); chk("br_nz", pc, 32'h40);
        zero = 1;
        step(); chk("br_z", pc, 32'h80);
        idle();

        // misaligned jump rejected, one-cycle pulse
        pc_write = 1; pc_src = 2'b10; jump_target = 32'h102;
        step(); chk("mis_pc", pc, 32'h80); chk("mis_pulse", misalign, 1);
        idle();
        step(); chk("mis_clr", misalign, 0); chk("mis_hold", pc, 32'h80);

        // register target
        pc_write = 1; pc_src = 2'b11; reg_target = 32'h200;
        step(); chk("reg_tgt", pc, 32'h200);
        idle();

        // exception beats load and push
        exc_req = 1; pc_write = 1; pc_src = 2'b00; ras_push = 1;
        step(); chk("exc_pc", pc, 32'hFC); chk("exc_epc", epc, 32'h200);
        chk("exc_ras", ras_empty, 1);
        idle();
        jump(32'h300); chk("epc_hold", epc, 32'h200);

        // five pushes into a depth-4 stack
        for (int i = 1; i <= 5; i++) begin
            jump(32'h10 * i);
            ras_push = 1;
            step();
            ras_push = 0;
            chk("push_top", ras_top, 32'h10 * i + 4);
            if (i == 4) chk("full_no_ovf", {ras_full, ras_ovf}, 2'b10);
        end
        chk("ovf_full", {ras_full, ras_ovf, ras_empty}, 3'b110);
        exp_top[0] = 32'h44; exp_top[1] = 32'h34; exp_top[2] = 32'h24; exp_top[3] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            ras_pop = 1;
            step();
            chk("pop_top", ras_top, exp_top[i]);
        end
        chk("pop_empty", ras_empty, 1);
        chk("no_unf", ras_unf, 0);
        step(); chk("unf", {ras_unf, ras_empty, ras_ovf}, 3'b111);
        ras_pop = 0;

        // push+pop on empty acts as push; on non-empty replaces top
        ras_push = 1; ras_pop = 1;
        step(); chk("pp_empty", ras_top, 32'h54); chk("pp_cnt1", ras_empty, 0);
        jump(32'h60);
        ras_push = 1; ras_pop = 1;
        step(); chk("pp_repl", ras_top, 32'h64);
        ras_push = 0;
        step(); chk("pp_cnt", ras_empty, 1);
        ras_pop = 0;

        // wrap at top of address space
        jump(32'hFFFF_FFFC); chk("jmp_top", pc, 32'hFFFF_FFFC);
        pc_write = 1; pc_src = 2'b00;
        step(); chk("wrap", pc, 32'h0);

        // asynchronous reset between edges, pending load discarded
        jump(32'h80);
        pc_write = 1; pc_src = 2'b00;
        #3;
        reset_n = 0;
        #1;
        chk("async_pc", pc, 32'h0);
        chk("async_flags", {ras_ovf, ras_unf, misalign}, 3'b000);
        step(); chk("held_rst", pc, 32'h0);
        @(negedge clk);
        reset_n = 1;
        step(); chk("first_upd", pc, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
